button_conditioner: RTL and testbench

Conditions the raw on-board push-button pin for the SoC. It sits between the `btn1` board pin and the SoC `btn` input, in the `soc_clk` domain. It synchronises the asynchronous pin, debounces it into a clean level, and produces one-cycle press, release and long-press pulses. The SoC can then poll or edge-trigger on the button without software debouncing.

---
 rtl/button_conditioner_if.sv | 30 +++
 rtl/button_conditioner.sv | 153 +++++++++++++++
 tb/tb_button_conditioner.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner_if
// Purpose  : Raw pin in, conditioned level and event pulses out.
// Revision : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;
  logic btn_in;
  logic btn;
  logic pressed;
  logic released;
  logic long_press;

  modport master (
    output btn_in,
    input  btn,
    input  pressed,
    input  released,
    input  long_press
  );

  modport slave (
    input  btn_in,
    output btn,
    output pressed,
    output released,
    output long_press
  );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronise, debounce and edge-detect a push-button pin.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int CLK_FREQ      = 20_250_000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 1000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  localparam int c_db_cycles   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int c_long_cycles = CLK_FREQ / 1000 * LONG_PRESS_MS;
  localparam int c_db_w        = $clog2(c_db_cycles + 1);
  localparam int c_hold_w      = $clog2(c_long_cycles + 1);

  localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(c_db_cycles - 1);
  localparam logic [c_hold_w-1:0] c_long_last = c_hold_w'(c_long_cycles - 1);
  localparam logic [c_hold_w-1:0] c_long_max  = c_hold_w'(c_long_cycles);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [c_db_w-1:0]     r_db_cnt;
  logic [c_hold_w-1:0]   r_hold_cnt;
  logic                  r_btn;
  logic                  r_pressed;
  logic                  r_released;
  logic                  r_long_press;

  logic w_s;
  logic w_db_hit;
  logic w_rel_commit;

  // r_db_cnt holds the stable samples already seen; the current sample is
  // the DB_CYCLES-th one when the count equals DB_CYCLES-1.
  assign w_s          = r_sync2 ^ ACTIVE_LOW;
  assign w_db_hit     = (r_db_cnt == c_db_last);
  assign w_rel_commit = (r_state == RELEASE_WAIT) && !w_s && w_db_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sync1      <= ACTIVE_LOW;
      r_sync2      <= ACTIVE_LOW;
      r_db_cnt     <= '0;
      r_hold_cnt   <= '0;
      r_btn        <= 1'b0;
      r_pressed    <= 1'b0;
      r_released   <= 1'b0;
      r_long_press <= 1'b0;
    end else begin
      r_sync1      <= bus.btn_in;
      r_sync2      <= r_sync1;
      r_pressed    <= 1'b0;
      r_released   <= 1'b0;
      r_long_press <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_s) begin
            if (w_db_hit) begin
              r_state   <= PRESSED;
              r_btn     <= 1'b1;
              r_pressed <= 1'b1;
              r_db_cnt  <= '0;
            end else begin
              r_state  <= PRESS_WAIT;
              r_db_cnt <= c_db_w'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (!w_s) begin
            r_state  <= IDLE;
            r_db_cnt <= '0;
          end else if (w_db_hit) begin
            r_state   <= PRESSED;
            r_btn     <= 1'b1;
            r_pressed <= 1'b1;
            r_db_cnt  <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + c_db_w'(1);
          end
        end
        PRESSED: begin
          if (!w_s) begin
            if (w_db_hit) begin
              r_state    <= IDLE;
              r_btn      <= 1'b0;
              r_released <= 1'b1;
              r_db_cnt   <= '0;
            end else begin
              r_state  <= RELEASE_WAIT;
              r_db_cnt <= c_db_w'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (w_s) begin
            r_state  <= PRESSED;
            r_db_cnt <= '0;
          end else if (w_db_hit) begin
            r_state    <= IDLE;
            r_btn      <= 1'b0;
            r_released <= 1'b1;
            r_db_cnt   <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + c_db_w'(1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_db_cnt <= '0;
        end
      endcase

      // Hold time keeps running through release bounce; a release that
      // commits on the same edge wins over the long-press pulse.
      if (r_btn) begin
        if (r_hold_cnt != c_long_max) begin
          r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
        end
        if ((r_hold_cnt == c_long_last) && !w_rel_commit
            && !((r_state == PRESSED) && !w_s && w_db_hit)) begin
          r_long_press <= 1'b1;
        end
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

  assign bus.btn        = r_btn;
  assign bus.pressed    = r_pressed;
  assign bus.released   = r_released;
  assign bus.long_press = r_long_press;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Scoreboard bench: expected events queued at stimulus time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam logic [2:0] EV_NONE = 3'b000;
  localparam logic [2:0] EV_P    = 3'b001;
  localparam logic [2:0] EV_R    = 3'b010;
  localparam logic [2:0] EV_L    = 3'b100;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
    logic       lvl;
  } ev_t;

  logic clk;
  logic rst;
  button_conditioner_if bus ();

  int   n_checks;
  int   n_fail;
  int   edge_n;
  logic exp_btn;
  ev_t  q[$];

  button_conditioner #(
    .CLK_FREQ      (1000),
    .DEBOUNCE_MS   (4),
    .LONG_PRESS_MS (20),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic push_ev(input int cyc, input logic [2:0] kind, input logic lvl);
    ev_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.lvl  = lvl;
    q.push_back(e);
  endtask

  // Drives the pin for n cycles; k is the edge that first samples it.
  task automatic hold_pin(input logic v, input int n, output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.btn_in = v;
      if (i == 0) k = edge_n + 1;
    end
  endtask

  always @(posedge clk) begin
    logic [2:0] fire;
    ev_t        e;
    #1;
    edge_n = edge_n + 1;
    fire = {bus.long_press, bus.released, bus.pressed};
    if (q.size() != 0 && q[0].cyc == edge_n) begin
      e = q.pop_front();
      chk_eq("event", 32'(fire), 32'(e.kind));
      exp_btn = e.lvl;
    end else begin
      chk_eq("quiet", 32'(fire), 32'(EV_NONE));
    end
    chk_eq("btn", 32'(bus.btn), 32'(exp_btn));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int e;
    int r;
    int d;
    n_checks   = 0;
    n_fail     = 0;
    edge_n     = 0;
    exp_btn    = 1'b0;
    rst        = 1'b1;
    bus.btn_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold_pin(1'b1, 5, d);

    // Clean press and short release
    hold_pin(1'b0, 1, k);
    push_ev(k + 5, EV_P, 1'b1);
    hold_pin(1'b0, 9, d);
    hold_pin(1'b1, 1, k);
    push_ev(k + 5, EV_R, 1'b0);
    hold_pin(1'b1, 10, d);

    // Press bounce shorter than the debounce window
    hold_pin(1'b0, 3, d);
    hold_pin(1'b1, 1, d);
    hold_pin(1'b0, 3, d);
    hold_pin(1'b1, 1, d);
    hold_pin(1'b1, 10, d);

    // Long press held 40 cycles past btn rise
    hold_pin(1'b0, 1, k);
    e = k + 5;
    push_ev(e, EV_P, 1'b1);
    push_ev(e + 20, EV_L, 1'b1);
    hold_pin(1'b0, 44, d);
    hold_pin(1'b1, 1, k);
    push_ev(k + 5, EV_R, 1'b0);
    hold_pin(1'b1, 10, d);

    // Release bounce while pressed
    hold_pin(1'b0, 1, k);
    e = k + 5;
    push_ev(e, EV_P, 1'b1);
    push_ev(e + 20, EV_L, 1'b1);
    hold_pin(1'b0, 7, d);
    repeat (6) begin
      hold_pin(1'b1, 2, d);
      hold_pin(1'b0, 3, d);
    end
    hold_pin(1'b0, 3, d);
    hold_pin(1'b1, 1, k);
    push_ev(k + 5, EV_R, 1'b0);
    hold_pin(1'b1, 10, d);

    // Reset mid-press, pin kept low throughout
    hold_pin(1'b0, 1, k);
    push_ev(k + 5, EV_P, 1'b1);
    hold_pin(1'b0, 9, d);
    @(negedge clk);
    rst = 1'b1;
    push_ev(edge_n + 1, EV_NONE, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    r = edge_n + 1;
    push_ev(r + 5, EV_P, 1'b1);
    push_ev(r + 25, EV_L, 1'b1);
    hold_pin(1'b0, 30, d);
    hold_pin(1'b1, 1, k);
    push_ev(k + 5, EV_R, 1'b0);
    hold_pin(1'b1, 10, d);

    // Release commits on the same edge the hold time would expire
    hold_pin(1'b0, 1, k);
    e = k + 5;
    push_ev(e, EV_P, 1'b1);
    while (edge_n + 2 < e + 15) hold_pin(1'b0, 1, d);
    hold_pin(1'b1, 1, k);
    chk_eq("coincide_edge", 32'(k + 5), 32'(e + 20));
    push_ev(k + 5, EV_R, 1'b0);
    hold_pin(1'b1, 25, d);

    hold_pin(1'b1, 5, d);
    chk_eq("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
